// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the multiply/divide unit: operation codes,
//               FSM state encoding and small operation-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Operation code presented on the op port of mult_div_unit.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  // Iterative unit control states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic op_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit holding the architectural HI/LO
//               registers. MULT/MULTU use radix-2 shift-add, DIV/DIVU use
//               restoring division, both on unsigned magnitudes with a final
//               sign correction. One step per cycle, BIT_SIZE steps.
// Ports       : clk        - clock, all state updates on rising edge
//               rstN       - asynchronous active-low reset
//               start      - launch op on srcA/srcB (ignored while busy)
//               op         - md_op_t operation code
//               srcA/srcB  - multiplicand/dividend, multiplier/divisor
//               mtHi/mtLo  - write srcA into HI/LO (IDLE and DONE only)
//               hiOut/loOut- HI (upper product / remainder),
//                            LO (lower product / quotient)
//               busy       - high while iterating
//               done       - one-cycle result pulse
//               divByZero  - pulses with done for a divide by zero
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int BIT_SIZE = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [BIT_SIZE-1:0] srcA,
  input  logic [BIT_SIZE-1:0] srcB,
  input  logic                mtHi,
  input  logic                mtLo,
  output logic [BIT_SIZE-1:0] hiOut,
  output logic [BIT_SIZE-1:0] loOut,
  output logic                busy,
  output logic                done,
  output logic                divByZero
);

  localparam int                c_CNT_W     = $clog2(BIT_SIZE);
  localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(BIT_SIZE - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  md_state_t               state_q, state_d;
  logic [c_CNT_W-1:0]      count_q, count_d;
  logic                    is_div_q, is_div_d;
  logic                    neg_res_q, neg_res_d;   // negate product / quotient
  logic                    neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic [BIT_SIZE-1:0]     opnd_q, opnd_d;         // |srcA| for multiply, |srcB| for divide
  logic [2*BIT_SIZE-1:0]   acc_q, acc_d;           // product accumulator / quotient shifter
  logic [BIT_SIZE-1:0]     rem_q, rem_d;           // partial remainder
  logic [BIT_SIZE-1:0]     hi_q, hi_d;
  logic [BIT_SIZE-1:0]     lo_q, lo_d;
  logic                    dbz_q, dbz_d;

  // --------------------------------------------------------------------------
  // Launch decode: operand magnitudes and result sign flags
  // --------------------------------------------------------------------------
  md_op_t              w_launch_op;
  logic                w_launch_div;
  logic                w_launch_sgn;
  logic                w_neg_a;
  logic                w_neg_b;
  logic                w_launch_dbz;
  logic [BIT_SIZE-1:0] w_mag_a;
  logic [BIT_SIZE-1:0] w_mag_b;

  assign w_launch_op = md_op_t'(op);

  always_comb begin
    w_launch_div = op_is_div(w_launch_op);
    w_launch_sgn = op_is_signed(w_launch_op);
    w_neg_a      = w_launch_sgn & srcA[BIT_SIZE-1];
    w_neg_b      = w_launch_sgn & srcB[BIT_SIZE-1];
    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(BIT_SIZE-1).
    w_mag_a      = w_neg_a ? -srcA : srcA;
    w_mag_b      = w_neg_b ? -srcB : srcB;
    w_launch_dbz = w_launch_div && (srcB == '0);
  end

  // --------------------------------------------------------------------------
  // One radix-2 step of the shared datapath
  // --------------------------------------------------------------------------
  logic [BIT_SIZE:0]     w_mul_sum;
  logic [BIT_SIZE:0]     w_div_shift;
  logic [BIT_SIZE:0]     w_div_diff;
  logic [2*BIT_SIZE-1:0] w_acc_step;
  logic [BIT_SIZE-1:0]   w_rem_step;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, keep the carry, shift right.
    w_mul_sum   = {1'b0, acc_q[2*BIT_SIZE-1:BIT_SIZE]}
                + {1'b0, ({BIT_SIZE{acc_q[0]}} & opnd_q)};
    // Divide: bring the next dividend bit into the remainder and trial
    // subtract; the borrow bit decides whether to restore.
    w_div_shift = {rem_q, acc_q[BIT_SIZE-1]};
    w_div_diff  = w_div_shift - {1'b0, opnd_q};

    if (is_div_q) begin
      w_acc_step = {acc_q[2*BIT_SIZE-1:BIT_SIZE], acc_q[BIT_SIZE-2:0], ~w_div_diff[BIT_SIZE]};
      w_rem_step = w_div_diff[BIT_SIZE] ? w_div_shift[BIT_SIZE-1:0]
                                        : w_div_diff[BIT_SIZE-1:0];
    end else begin
      w_acc_step = {w_mul_sum, acc_q[BIT_SIZE-1:1]};
      w_rem_step = rem_q;
    end
  end

  // --------------------------------------------------------------------------
  // Sign correction of the final step
  // --------------------------------------------------------------------------
  logic [2*BIT_SIZE-1:0] w_prod_fix;
  logic [BIT_SIZE-1:0]   w_quo_fix;
  logic [BIT_SIZE-1:0]   w_rem_fix;
  logic [BIT_SIZE-1:0]   w_res_hi;
  logic [BIT_SIZE-1:0]   w_res_lo;

  always_comb begin
    w_prod_fix = neg_res_q ? -w_acc_step : w_acc_step;
    w_quo_fix  = neg_res_q ? -w_acc_step[BIT_SIZE-1:0] : w_acc_step[BIT_SIZE-1:0];
    w_rem_fix  = neg_rem_q ? -w_rem_step : w_rem_step;
    if (is_div_q) begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end else begin
      w_res_hi = w_prod_fix[2*BIT_SIZE-1:BIT_SIZE];
      w_res_lo = w_prod_fix[BIT_SIZE-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = 1'b0;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        // In DONE the result is already in HI/LO, so these writes land on
        // the following edge. A result launched here overwrites them later.
        if (mtHi) hi_d = srcA;
        if (mtLo) lo_d = srcA;

        if (start) begin
          if (w_launch_dbz) begin
            state_d = MD_DONE;
            dbz_d   = 1'b1;
          end else begin
            state_d   = MD_CALC;
            count_d   = '0;
            is_div_d  = w_launch_div;
            neg_res_d = w_neg_a ^ w_neg_b;
            neg_rem_d = w_neg_a;
            opnd_d    = w_launch_div ? w_mag_b : w_mag_a;
            acc_d     = {{BIT_SIZE{1'b0}}, (w_launch_div ? w_mag_a : w_mag_b)};
            rem_d     = '0;
          end
        end else begin
          state_d = MD_IDLE;
        end
      end

      MD_CALC: begin
        acc_d   = w_acc_step;
        rem_d   = w_rem_step;
        count_d = count_q + 1'b1;
        if (count_q == c_LAST_STEP) begin
          state_d = MD_DONE;
          count_d = '0;
          hi_d    = w_res_hi;
          lo_d    = w_res_lo;
        end
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hiOut     = hi_q;
  assign loOut     = lo_q;
  assign busy      = (state_q == MD_CALC);
  assign done      = (state_q == MD_DONE);
  assign divByZero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Directed vectors,
//               timing scenarios and randomized operations compared against
//               a 64-bit arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        mtHi;
  logic        mtLo;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        busy;
  logic        done;
  logic        divByZero;

  int checks   = 0;
  int failures = 0;

  // Architectural HI/LO as the reference model sees them.
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  mult_div_unit #(.BIT_SIZE(32)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .mtHi      (mtHi),
    .mtLo      (mtLo),
    .hiOut     (hiOut),
    .loOut     (loOut),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  // Reference: returns {HI, LO} for a non-zero-divisor operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; return p; end
      2'b10: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Launch one operation from an idle/done slot and wait for done.
  // lat is the cycle number (1 = first cycle after the sampling edge) in
  // which done was seen; 100 means it never came.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output logic bz);
    @(negedge clk);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); srcA = $urandom; srcB = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hi = hiOut; lo = loOut; dz = divByZero; bz = busy;
  endtask

  task automatic mt_write(input logic hi_sel, input logic [31:0] val);
    @(negedge clk);
    srcA = val; mtHi = hi_sel; mtLo = ~hi_sel;
    @(negedge clk);
    mtHi = 1'b0; mtLo = 1'b0;
    if (hi_sel) exp_hi = val; else exp_lo = val;
  endtask

  task automatic test_reset;
    rstN = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0; mtHi = 1'b0; mtLo = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hiOut !== 32'h0)   begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hiOut); end
    checks++; if (loOut !== 32'h0)   begin failures++; $display("FAIL reset_lo: got %h expected 00000000", loOut); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (divByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b expected 0", divByZero); end
    rstN = 1'b1;
    exp_hi = 32'h0; exp_lo = 32'h0;
  endtask

  task automatic test_mult_latency;
    int lat = 1;
    int busy_bad = 0;
    @(negedge clk);
    op = 2'b00; srcA = 32'd7; srcB = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency: done in cycle %0d expected 33", lat); end
    checks++; if (busy_bad != 0) begin failures++; $display("FAIL mult_busy: %0d cycles without busy expected 0", busy_bad); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
    checks++; if (hiOut !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_7x-3_hi: got %h expected ffffffff", hiOut); end
    checks++; if (loOut !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_7x-3_lo: got %h expected ffffffeb", loOut); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_vectors;
    logic [1:0]  v_op [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] v_a  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] v_b  [4] = '{32'hFFFF_FFFF, 32'd2,         32'd7,   32'hFFFF_FFFF};
    logic [31:0] v_hi [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2,   32'h0};
    logic [31:0] v_lo [4] = '{32'h0000_0001, 32'hFFFF_FFFD, 32'd14,  32'h8000_0000};
    int lat; logic [31:0] hi, lo; logic dz, bz;
    for (int i = 0; i < 4; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], lat, hi, lo, dz, bz);
      checks++; if (lat != 33 || dz !== 1'b0) begin failures++; $display("FAIL vec%0d_timing: lat=%0d dbz=%b expected 33/0", i, lat, dz); end
      checks++; if (hi !== v_hi[i]) begin failures++; $display("FAIL vec%0d_hi: got %h expected %h", i, hi, v_hi[i]); end
      checks++; if (lo !== v_lo[i]) begin failures++; $display("FAIL vec%0d_lo: got %h expected %h", i, lo, v_lo[i]); end
      exp_hi = v_hi[i]; exp_lo = v_lo[i];
    end
  endtask

  task automatic test_div_by_zero;
    int lat; logic [31:0] hi, lo; logic dz, bz;
    mt_write(1'b1, 32'hA);
    mt_write(1'b0, 32'hB);
    run_op(2'b11, 32'd5, 32'd0, lat, hi, lo, dz, bz);
    checks++; if (lat != 1) begin failures++; $display("FAIL dbz_latency: done in cycle %0d expected 1", lat); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %b expected 1", dz); end
    checks++; if (bz !== 1'b0) begin failures++; $display("FAIL dbz_busy: got %b expected 0", bz); end
    checks++; if (hi !== 32'hA || lo !== 32'hB) begin failures++; $display("FAIL dbz_hilo: got %h/%h expected 0000000a/0000000b", hi, lo); end
    @(negedge clk);
    checks++; if (divByZero !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL dbz_pulse: dbz=%b done=%b expected 0/0", divByZero, done); end
  endtask

  task automatic test_restart_and_abort;
    int lat = 1;
    logic [63:0] e;
    @(negedge clk);
    op = 2'b00; srcA = 32'h0001_2345; srcB = 32'hFFFF_0678; start = 1'b1;
    e = model(2'b00, 32'h0001_2345, 32'hFFFF_0678);
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 10) begin op = 2'b11; srcA = 32'd50; srcB = 32'd3; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++; if (lat != 33) begin failures++; $display("FAIL restart_latency: done in cycle %0d expected 33", lat); end
    checks++; if ({hiOut, loOut} !== e) begin failures++; $display("FAIL restart_result: got %h expected %h", {hiOut, loOut}, e); end
    exp_hi = e[63:32]; exp_lo = e[31:0];

    // Abort a fresh operation with an asynchronous reset in cycle 15.
    @(negedge clk);
    op = 2'b01; srcA = $urandom; srcB = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (hiOut !== 32'h0 || loOut !== 32'h0) begin failures++; $display("FAIL abort_hilo: got %h/%h expected 0/0", hiOut, loOut); end
    @(negedge clk);
    rstN = 1'b1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle: done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_mt_and_back_to_back;
    int lat = 1;
    int lo_bad = 0;
    logic [63:0] e;
    // MTHI in IDLE
    @(negedge clk);
    srcA = 32'h1234; mtHi = 1'b1;
    @(negedge clk);
    mtHi = 1'b0;
    checks++; if (hiOut !== 32'h1234) begin failures++; $display("FAIL mthi_idle: got %h expected 00001234", hiOut); end
    mt_write(1'b0, 32'h5555);

    // MTLO during CALC must not touch LO
    e = model(2'b01, 32'h89AB_CDEF, 32'h1357_9BDF);
    @(negedge clk);
    op = 2'b01; srcA = 32'h89AB_CDEF; srcB = 32'h1357_9BDF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      mtLo = (lat == 5); srcA = 32'hDEAD_0000 | lat;
      if (lat > 5 && loOut !== 32'h5555) lo_bad++;
      @(negedge clk);
      lat++;
    end
    mtLo = 1'b0;
    checks++; if (lo_bad != 0) begin failures++; $display("FAIL mtlo_busy: LO changed in %0d cycles expected 0", lo_bad); end
    checks++; if (lat != 33 || {hiOut, loOut} !== e) begin failures++; $display("FAIL mtlo_result: lat=%0d got %h expected 33/%h", lat, {hiOut, loOut}, e); end

    // In DONE: MTHI and a new start on the same cycle
    op = 2'b11; srcA = 32'hBEEF; srcB = 32'd7; start = 1'b1; mtHi = 1'b1;
    e = model(2'b11, 32'hBEEF, 32'd7);
    @(negedge clk);
    start = 1'b0; mtHi = 1'b0; srcA = $urandom; srcB = $urandom;
    checks++; if (hiOut !== 32'hBEEF || busy !== 1'b1) begin failures++; $display("FAIL b2b_mthi: hi=%h busy=%b expected 0000beef/1", hiOut, busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency: done in cycle %0d expected 33", lat); end
    checks++; if ({hiOut, loOut} !== e) begin failures++; $display("FAIL b2b_result: got %h expected %h", {hiOut, loOut}, e); end
    exp_hi = e[63:32]; exp_lo = e[31:0];
  endtask

  task automatic test_random;
    int lat; logic [31:0] hi, lo, a, b; logic dz, bz; logic [1:0] o;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      run_op(o, a, b, lat, hi, lo, dz, bz);
      if (o[1] && b == 32'h0) begin
        checks++; if (lat != 1 || dz !== 1'b1) begin failures++; $display("FAIL rand%0d_dbz: lat=%0d dbz=%b expected 1/1", i, lat, dz); end
        checks++; if (hi !== exp_hi || lo !== exp_lo) begin failures++; $display("FAIL rand%0d_dbz_hilo: got %h/%h expected %h/%h", i, hi, lo, exp_hi, exp_lo); end
      end else begin
        e = model(o, a, b);
        checks++; if (lat != 33 || dz !== 1'b0) begin failures++; $display("FAIL rand%0d_timing: op=%0d lat=%0d dbz=%b expected 33/0", i, o, lat, dz); end
        checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL rand%0d_result: op=%0d a=%h b=%h got %h expected %h", i, o, a, b, {hi, lo}, e); end
        exp_hi = e[63:32]; exp_lo = e[31:0];
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult_latency;
    test_vectors;
    test_div_by_zero;
    test_restart_and_abort;
    test_mt_and_back_to_back;
    test_random;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
